// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, FSM states and blanking rule for the 7-seg display scan
package display_pkg;

  localparam int N_DIGITOS = 6;
  localparam int BCD_W     = 21;
  localparam int SIGNO_BIT = 20;

  typedef enum logic {INACTIVO, BARRIDO} estado_t;

  // Slot 0 always shows a digit; slots 1..4 hide leading zeros; slot 5 shows only a minus sign.
  function automatic logic en_blanco(input logic [BCD_W-1:0] codigo, input logic [2:0] pos);
    logic ceros;
    en_blanco = 1'b1;
    ceros     = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      ceros = ceros & (codigo[4*k +: 4] == 4'd0);
      if (pos == 3'(k)) en_blanco = ceros;
    end
    if (pos == 3'd0) en_blanco = 1'b0;
    if (pos == 3'd5) en_blanco = ~codigo[SIGNO_BIT];
  endfunction

endpackage

// File: rtl/controlador_display_if.sv
// rtl/controlador_display_if.sv - result handshake from binario_a_BCD into the display controller
interface controlador_display_if;

  logic [display_pkg::BCD_W-1:0] codigo_BCD_in;
  logic                          valido;
  logic                          aceptado;

  modport master (output codigo_BCD_in, output valido, input aceptado);
  modport slave  (input codigo_BCD_in, input valido, output aceptado);

endinterface

// File: rtl/divisor_refresco.sv
// rtl/divisor_refresco.sv - prescaler producing one tick every DIV clock cycles
module divisor_refresco #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cuenta_q, cuenta_d;

  assign tick = (cuenta_q == W'(DIV - 1));

  always_comb begin
    cuenta_d = tick ? '0 : cuenta_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cuenta_q <= '0;
    else     cuenta_q <= cuenta_d;
  end

endmodule

// File: rtl/controlador_display.sv
// rtl/controlador_display.sv - time-multiplexed 7-seg scan of a signed 6-digit BCD result
// New results are held pending and only swapped in at frame boundaries so a frame never tears.
module controlador_display
  import display_pkg::*;
#(
  parameter int N_ANODOS     = 8,
  parameter int DIV_REFRESCO = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 encendido,
  controlador_display_if.slave bus,
  output logic [BCD_W-1:0]     codigo_BCD,
  output logic [2:0]           contador_actualizar,
  output logic [N_ANODOS-1:0]  anodos
);

  logic                tick, fin_trama;
  estado_t             estado_q, estado_d;
  logic [2:0]          contador_q, contador_d;
  logic [BCD_W-1:0]    codigo_q, codigo_d, pend_q, pend_d;
  logic                pendiente_q, pendiente_d;
  logic                aceptado_q, aceptado_d;
  logic                hay_codigo_q, hay_codigo_d;
  logic [N_ANODOS-1:0] anodos_q, anodos_d;

  divisor_refresco #(.DIV(DIV_REFRESCO)) u_divisor (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign fin_trama = tick && (contador_q == 3'(N_DIGITOS - 1));

  always_comb begin
    contador_d = contador_q;
    if (tick) contador_d = (contador_q == 3'(N_DIGITOS - 1)) ? 3'd0 : contador_q + 3'd1;

    pend_d       = pend_q;
    pendiente_d  = pendiente_q;
    codigo_d     = codigo_q;
    aceptado_d   = 1'b0;
    hay_codigo_d = hay_codigo_q;
    if (bus.valido) begin
      pend_d      = bus.codigo_BCD_in;
      pendiente_d = 1'b1;
    end
    // A strobe landing on the boundary itself bypasses the pending register.
    if (fin_trama) begin
      if (bus.valido) begin
        codigo_d   = bus.codigo_BCD_in;
        aceptado_d = 1'b1;
      end else if (pendiente_q) begin
        codigo_d   = pend_q;
        aceptado_d = 1'b1;
      end
      pendiente_d = 1'b0;
    end
    if (aceptado_d) hay_codigo_d = 1'b1;

    estado_d = estado_q;
    case (estado_q)
      INACTIVO: if (encendido && (aceptado_d || (tick && hay_codigo_q))) estado_d = BARRIDO;
      BARRIDO:  if (!encendido) estado_d = INACTIVO;
      default:  estado_d = INACTIVO;
    endcase

    // Built from next-state slot and code so anodes move on the same edge as the counter.
    anodos_d = '1;
    if (estado_d == BARRIDO && !en_blanco(codigo_d, contador_d)) begin
      for (int i = 0; i < N_ANODOS; i++) begin
        if (int'(contador_d) == i) anodos_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q     <= INACTIVO;
      contador_q   <= 3'd0;
      codigo_q     <= '0;
      pend_q       <= '0;
      pendiente_q  <= 1'b0;
      aceptado_q   <= 1'b0;
      hay_codigo_q <= 1'b0;
      anodos_q     <= '1;
    end else begin
      estado_q     <= estado_d;
      contador_q   <= contador_d;
      codigo_q     <= codigo_d;
      pend_q       <= pend_d;
      pendiente_q  <= pendiente_d;
      aceptado_q   <= aceptado_d;
      hay_codigo_q <= hay_codigo_d;
      anodos_q     <= anodos_d;
    end
  end

  assign bus.aceptado        = aceptado_q;
  assign codigo_BCD          = codigo_q;
  assign contador_actualizar = contador_q;
  assign anodos              = anodos_q;

endmodule

// File: tb/tb_controlador_display.sv
// tb/tb_controlador_display.sv - scoreboard bench for controlador_display with a 4-cycle slot
module tb_controlador_display;
  import display_pkg::*;

  localparam int DIV   = 4;
  localparam int TRAMA = DIV * N_DIGITOS;

  typedef struct {
    logic [BCD_W-1:0] codigo;
    int               trama;
  } esperado_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             encendido = 1'b0;
  logic [BCD_W-1:0] codigo_BCD;
  logic [2:0]       contador_actualizar;
  logic [7:0]       anodos;

  controlador_display_if bus ();

  controlador_display #(.N_ANODOS(8), .DIV_REFRESCO(DIV)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .encendido           (encendido),
    .bus                 (bus),
    .codigo_BCD          (codigo_BCD),
    .contador_actualizar (contador_actualizar),
    .anodos              (anodos)
  );

  always #5 clk = ~clk;

  esperado_t        cola[$];
  int               n = 0;
  int               checks = 0;
  int               errors = 0;
  int               modo = 0;
  logic [BCD_W-1:0] codigo_vis = '0;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic logic [7:0] anodos_ref(input logic [BCD_W-1:0] c, input int slot);
    int         msd;
    logic       visible;
    logic [7:0] r;
    msd = 0;
    for (int d = 0; d < 5; d++) if (c[4*d +: 4] != 4'd0) msd = d;
    visible = (slot == 5) ? c[SIGNO_BIT] : (slot <= msd);
    r = 8'hFF;
    if (visible) r[slot] = 1'b0;
    return r;
  endfunction

  task automatic paso();
    esperado_t e;
    @(posedge clk);
    n = rst ? 0 : n + 1;
    @(negedge clk);
    if (modo == 3 && (n % DIV) == 0) modo = 1;
    comprobar("contador", 32'(contador_actualizar), 32'((n / DIV) % N_DIGITOS));
    if (bus.aceptado === 1'b1) begin
      if (cola.size() == 0) begin
        comprobar("aceptado_sin_pendiente", 32'(bus.aceptado), 32'd0);
      end else begin
        e = cola.pop_front();
        comprobar("codigo_BCD", 32'(codigo_BCD), 32'(e.codigo));
        comprobar("ciclo_aceptado", 32'(n), 32'(TRAMA * (e.trama + 1)));
        codigo_vis = e.codigo;
        if (encendido && modo == 0) modo = 1;
      end
    end
    if (modo == 0 || modo == 3)
      comprobar("anodos_apagados", 32'(anodos), 32'h0000_00FF);
    else if (modo == 1)
      comprobar("anodos_barrido", 32'(anodos), 32'(anodos_ref(codigo_vis, (n / DIV) % N_DIGITOS)));
  endtask

  task automatic avanzar(input int ciclos);
    for (int i = 0; i < ciclos; i++) paso();
  endtask

  task automatic enviar(input logic [BCD_W-1:0] c);
    esperado_t e;
    e.codigo = c;
    e.trama  = n / TRAMA;
    if (cola.size() > 0 && cola[$].trama == e.trama) void'(cola.pop_back());
    cola.push_back(e);
    bus.valido        = 1'b1;
    bus.codigo_BCD_in = c;
    paso();
    bus.valido = 1'b0;
  endtask

  task automatic esperar_aceptado();
    for (int i = 0; i < 3 * TRAMA && cola.size() > 0; i++) paso();
    comprobar("timeout_aceptado", 32'(cola.size()), 32'd0);
  endtask

  initial begin
    bus.valido        = 1'b0;
    bus.codigo_BCD_in = '0;
    rst               = 1'b1;
    encendido         = 1'b0;

    avanzar(3);
    comprobar("reset_anodos", 32'(anodos), 32'h0000_00FF);
    comprobar("reset_contador", 32'(contador_actualizar), 32'd0);
    comprobar("reset_codigo", 32'(codigo_BCD), 32'd0);
    comprobar("reset_aceptado", 32'(bus.aceptado), 32'd0);
    rst       = 1'b0;
    encendido = 1'b1;
    avanzar(5);

    enviar(21'h0_12345);
    esperar_aceptado();
    avanzar(TRAMA + 2);

    enviar(21'h1_00007);
    esperar_aceptado();
    avanzar(TRAMA);

    enviar(21'h0_00001);
    avanzar(2);
    enviar(21'h0_00002);
    esperar_aceptado();
    comprobar("ultimo_gana", 32'(codigo_BCD), 32'h0000_0002);
    avanzar(4);

    for (int i = 0; i < TRAMA && (n % TRAMA) != TRAMA - 1; i++) paso();
    enviar(21'h1_00050);
    comprobar("aceptado_en_fin_trama", 32'(cola.size()), 32'd0);
    avanzar(TRAMA + 4);
    comprobar("codigo_tras_fin_trama", 32'(codigo_BCD), 32'h0010_0050);

    enviar(21'h0_00099);
    avanzar(3);
    rst        = 1'b1;
    modo       = 0;
    codigo_vis = '0;
    cola.delete();
    paso();
    rst = 1'b0;
    comprobar("rst_medio_codigo", 32'(codigo_BCD), 32'd0);
    comprobar("rst_medio_aceptado", 32'(bus.aceptado), 32'd0);
    avanzar(2 * TRAMA);

    enviar(21'h0_00123);
    esperar_aceptado();
    avanzar(7);
    encendido = 1'b0;
    modo      = 0;
    avanzar(2 * DIV + 1);
    encendido = 1'b1;
    modo      = 3;
    avanzar(TRAMA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
